// File: rtl/lsu_mem_if.sv
// Request/response bus between the core load/store path and lsu_mem.
// The master side is the core; the slave side is the memory.
interface lsu_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_mem.sv
// Multicycle RV32 load/store data memory: byte/half/word lanes, load extension, wait states.
// Define LSU_MEM_CHECK_EN for misalign/range/funct3 error checking; otherwise legacy wrapping.
module lsu_mem #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input logic      clk,
    input logic      rst,
    lsu_mem_if.slave bus
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [3:0]  CntInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q;
    logic [3:0]  count_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem [DEPTH];

    logic          a_we;
    logic [31:0]   a_addr;
    logic [2:0]    a_funct3;
    logic [31:0]   a_wdata;
    logic [1:0]    size;
    logic [1:0]    off;
    logic [AW-1:0] idx;
    logic          err;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [31:0]   shifted;
    logic [31:0]   ext;
    logic          commit;

    // With no wait states the access commits on the acceptance edge, straight from the bus.
    always_comb begin
        if (LATENCY == 0) begin
            a_we     = bus.req_we;
            a_addr   = bus.req_addr;
            a_funct3 = bus.req_funct3;
            a_wdata  = bus.req_wdata;
        end else begin
            a_we     = we_q;
            a_addr   = addr_q;
            a_funct3 = funct3_q;
            a_wdata  = wdata_q;
        end
    end

`ifndef LSU_MEM_CHECK_EN
    logic unused_addr_hi;
    assign unused_addr_hi = ^a_addr[31:AW+2];
`endif

    always_comb begin
        err  = 1'b0;
        size = a_funct3[1:0];
        idx  = a_addr[AW+1:2];
`ifdef LSU_MEM_CHECK_EN
        if (a_funct3[1:0] == 2'b11 || a_funct3 == 3'b110) err = 1'b1;
        if (a_we && a_funct3[2]) err = 1'b1;
        if (a_funct3[1:0] == 2'b01 && a_addr[0]) err = 1'b1;
        if (a_funct3[1:0] == 2'b10 && a_addr[1:0] != 2'b00) err = 1'b1;
        if (|a_addr[31:AW+2]) err = 1'b1;
`else
        if (a_funct3[1:0] == 2'b11) size = 2'b10;
`endif
        case (size)
            2'b00: begin
                off    = a_addr[1:0];
                be     = 4'b0001 << off;
                wlanes = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                off    = {a_addr[1], 1'b0};
                be     = a_addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{a_wdata[15:0]}};
            end
            default: begin
                off    = 2'b00;
                be     = 4'b1111;
                wlanes = a_wdata;
            end
        endcase
        shifted = mem[idx] >> {off, 3'b000};
        case (size)
            2'b00: ext = a_funct3[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: ext = a_funct3[2] ? {16'b0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    assign commit = (state_q == StWait && count_q == 4'd0) ||
                    (LATENCY == 0 && state_q == StIdle && bus.req_valid);

    // Gated by rst so a store pending at reset can never land in the array.
    always_ff @(posedge clk) begin
        if (commit && a_we && !err && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            funct3_q    <= 3'd0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        addr_q   <= bus.req_addr;
                        funct3_q <= bus.req_funct3;
                        wdata_q  <= bus.req_wdata;
                        if (LATENCY == 0) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= err;
                            rsp_rdata_q <= (!a_we && !err) ? ext : 32'd0;
                        end else begin
                            state_q <= StWait;
                            count_q <= CntInit;
                        end
                    end
                end
                StWait: begin
                    if (count_q == 4'd0) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err;
                        rsp_rdata_q <= (!a_we && !err) ? ext : 32'd0;
                    end else begin
                        count_q <= count_q - 4'd1;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
